// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the x^4+x+1 LFSR word stream.
// Latency: all outputs registered, updated on the edge that samples a valid word.
// Backpressure: none; accepts one word per cycle whenever din_valid is high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din        received 4-bit LFSR word, sampled when din_valid==1
//   din_valid  qualifies din; when low all state holds
//   clr_cnt    synchronous clear of err_count (a coincident error is kept)
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse per mispredicted word while LOCKED
//   err_count  saturating count of mispredicted words while LOCKED
//   stuck_zero last valid word was all-zero
module lfsr_checker #(
    parameter int unsigned LOCK_MATCHES = 4,
    parameter int unsigned LOSS_MISSES  = 3,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             stuck_zero
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_MATCHES);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_MISSES);

    state_t           state_q;
    logic [3:0]       prev_q;
    logic             prev_valid_q;
    logic [3:0]       run_q;
    logic [3:0]       miss_q;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_count_q;
    logic [ERR_W-1:0] err_count_d;
    logic             stuck_zero_q;

    logic [3:0] expected;
    logic       is_match;
    logic [3:0] run_inc;
    logic [3:0] miss_inc;
    logic       err_inc;

    // Same update as the generator: new MSB = Q1^Q0, then shift right.
    assign expected = {prev_q[1] ^ prev_q[0], prev_q[3:1]};
    // All-zero is the LFSR lock-up state and can never be a legal word.
    assign is_match = prev_valid_q && (din == expected) && (din != 4'b0000);
    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;
    assign err_inc  = din_valid && (state_q == LOCKED) && !is_match;

    // A clear never discards an error arriving in the same cycle.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_cnt) begin
            err_count_d = err_inc ? ERR_W'(1) : '0;
        end else if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SEARCH;
            prev_q       <= 4'b0000;
            prev_valid_q <= 1'b0;
            run_q        <= 4'd0;
            miss_q       <= 4'd0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            stuck_zero_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            err_count_q <= err_count_d;
            if (din_valid) begin
                stuck_zero_q <= (din == 4'b0000);
                case (state_q)
                    SEARCH: begin
                        prev_q       <= din;
                        prev_valid_q <= 1'b1;
                        if (is_match) begin
                            if (run_inc == LOCK_CNT) begin
                                state_q <= LOCKED;
                                run_q   <= 4'd0;
                                miss_q  <= 4'd0;
                            end else begin
                                run_q <= run_inc;
                            end
                        end else begin
                            run_q <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (is_match) begin
                            miss_q <= 4'd0;
                            prev_q <= din;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (miss_inc == LOSS_CNT) begin
                                // Give up the flywheel and resynchronise on the raw input.
                                state_q <= SEARCH;
                                run_q   <= 4'd0;
                                miss_q  <= 4'd0;
                                prev_q  <= din;
                                if (din == 4'b0000) begin
                                    prev_valid_q <= 1'b0;
                                end
                            end else begin
                                // Flywheel: keep predicting from the expected word so a
                                // single corrupted word costs exactly one error.
                                miss_q <= miss_inc;
                                prev_q <= expected;
                            end
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
        end
    end

    assign locked     = (state_q == LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign stuck_zero = stuck_zero_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the 4-bit LFSR pattern generator: takes the generator's parallel word stream and self-synchronises to it. Once synchronised, it flags and counts any word that breaks the x^4+x+1 sequence. It sits on the receive side of a loopback or test path and reports lock, per-word error pulses, a saturating error count and an all-zero (lock-up) condition.

## Interface
- LOCK_MATCHES, 4: consecutive correct predictions required to enter LOCKED (legal 1..15).
- LOSS_MISSES, 3: consecutive mispredictions in LOCKED that force return to SEARCH (legal 1..15).
- ERR_W, 8: width of err_count.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (rst==0 resets immediately).
- din  input  4  received LFSR word.
- din_valid  input  1  din is sampled only on cycles with din_valid==1.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse per mispredicted word while LOCKED.
- err_count  output  ERR_W  saturating count of mispredicted words while LOCKED.
- stuck_zero  output  1  last valid word was 4'b0000.

## Operation
- Internal: prev[3:0], prev_valid, state {SEARCH, LOCKED}, run counter, miss counter (4 bits each).
- Prediction: expected = {prev[1]^prev[0], prev[3:1]}. This matches the generator's update: new bit 3 = Q1^Q0, then shift right.
- match = prev_valid && din==expected && din!=4'b0000. All-zero is never a match.
- Only din_valid cycles advance anything. When din_valid==0, all state holds and err_pulse==0.
- SEARCH, valid word:
  - match: run+1. If run+1==LOCK_MATCHES, go to LOCKED and clear run and miss.
  - no match: run=0.
  - In both cases prev<=din and prev_valid<=1.
- LOCKED, valid word:
  - match: miss=0, prev<=din.
  - mismatch: err_pulse=1, err_count+1 (saturates at all-ones), miss+1, and prev<=expected. This flywheel step means a single corrupted word costs exactly one error.
  - If miss+1==LOSS_MISSES: go to SEARCH, run=0, prev<=din, and clear prev_valid=0 only if din==0.
- stuck_zero: set on a valid word equal to 0, cleared on a valid nonzero word. It is independent of state.
- clr_cnt:
  - err_count<=0 on that cycle.
  - If clr_cnt coincides with an error increment, err_count<=1 (the new error is kept).
  - clr_cnt does not affect state or the other outputs.
- Reset (any time, including mid-lock): state=SEARCH, prev=0, prev_valid=0, run=0, miss=0, locked=0, err_pulse=0, err_count=0, stuck_zero=0.

## Timing
- All outputs are registered and update on the rising edge that samples the valid word.
- locked rises in the cycle after the valid word that completes LOCK_MATCHES matches. From a clean stream starting at the first word, that is the edge sampling word number LOCK_MATCHES+1.
- err_pulse is high for exactly one cycle, the cycle after the bad word is sampled, together with the err_count increment.
- locked falls the cycle after the LOSS_MISSES-th consecutive miss. That final miss still pulses err_pulse and still counts.
- Back-to-back valid words are supported at full rate; there is no backpressure.
- Reference sequence for the generator seed 0110: 0110,1011,0101,1010,1101,1110,1111,0111,0011,0001,1000,0100,0010,1001,1100, then repeat (period 15).

## Test plan
- Lock: reset, then drive the reference sequence at one word per cycle. Required: locked==1 after the 5th word is sampled, err_pulse never asserts, err_count==0 over 100 words.
- Single error: while locked, replace 1010 with 1000, then resume the correct sequence. Required: exactly one err_pulse, err_count==1, locked stays 1, the following word 1101 matches.
- Loss of lock: while locked, drive 3 arbitrary words that fail prediction. Required: 3 pulses, err_count==3, locked==0 after the 3rd. Then resume the correct sequence and require relock 4 matches later.
- Stuck zero: while locked, drive 0000 three times. Required: stuck_zero==1, 3 errors, locked==0. On the next nonzero valid word, stuck_zero==0.
- Gaps and clear: insert din_valid==0 gaps between correct words; lock must still form with no errors. Assert clr_cnt in the same cycle as a corrupted word and require err_count==1. Force 300 errors with ERR_W=8 and require err_count to saturate at 255.
- Async reset: assert rst=0 mid-lock, between clock edges. Required: locked and err_count go to 0 immediately, before the next edge. After release, relock behaves as in the first scenario.
